if_fetch_sequencer: RTL and testbench

Controller for the fetch-stage PC register and the instruction-memory read port. It holds the fetch PC and issues reads, honouring memory busywait. It delivers fetched instructions into the IF/ID register with a valid bit, honouring pipeline stalls from the hazard unit. It applies branch/jump redirects from EX, squashing wrong-path fetches, including a read still outstanding in memory.

---
 rtl/if_fetch_sequencer_if.sv | 25 ++
 rtl/if_fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_if_fetch_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_sequencer_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory read port and IF/ID outputs.
// The sequencer drives the master side; pipeline and memory sit on the slave side.
interface if_fetch_sequencer_if;
    logic        STALL;
    logic        REDIRECT_EN;
    logic [31:0] REDIRECT_ADDR;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IMEM_INSTR;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] PC_OUT;
    logic [31:0] INSTR_OUT;
    logic        INSTR_VALID;
    logic        FLUSH;

    modport master (
        input  STALL, REDIRECT_EN, REDIRECT_ADDR, IMEM_BUSYWAIT, IMEM_INSTR,
        output IMEM_READ, IMEM_ADDR, PC_OUT, INSTR_OUT, INSTR_VALID, FLUSH
    );

    modport slave (
        output STALL, REDIRECT_EN, REDIRECT_ADDR, IMEM_BUSYWAIT, IMEM_INSTR,
        input  IMEM_READ, IMEM_ADDR, PC_OUT, INSTR_OUT, INSTR_VALID, FLUSH
    );
endinterface

// File: rtl/if_fetch_sequencer.sv
// Fetch PC sequencer: issues instruction reads, fills the IF/ID register, buffers one
// instruction across stalls and drains an in-flight read after a redirect.
module if_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4
) (
    input logic                  CLOCK,
    input logic                  RESET,
    if_fetch_sequencer_if.master bus
);
    localparam logic [31:0] Nop  = 32'h0000_0013;
    localparam logic [31:0] Step = 32'(PC_STEP);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;

    logic        imem_read;
    logic [31:0] imem_addr;
    logic        done;
    logic [31:0] redirect_pc;

    assign imem_read   = (state_q == StFetch) || (state_q == StDrain);
    assign imem_addr   = (state_q == StDrain) ? drain_addr_q : fetch_pc_q;
    assign done        = imem_read && !bus.IMEM_BUSYWAIT;
    assign redirect_pc = bus.REDIRECT_ADDR & ~32'h3;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        pc_out_d     = pc_out_q;
        instr_out_d  = instr_out_q;
        valid_d      = valid_q;
        flush_d      = 1'b0;

        if (bus.REDIRECT_EN) begin
            // Redirect beats stall and any data returned this cycle.
            fetch_pc_d   = redirect_pc;
            valid_d      = 1'b0;
            flush_d      = 1'b1;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            unique case (state_q)
                StFetch: begin
                    if (bus.IMEM_BUSYWAIT) begin
                        drain_addr_d = imem_addr;
                        state_d      = StDrain;
                    end else begin
                        state_d = StFetch;
                    end
                end
                // Keep draining only while the old read is still in flight.
                StDrain: state_d = done ? StFetch : StDrain;
                default: state_d = StFetch;
            endcase
        end else begin
            unique case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    if (done) begin
                        if (!bus.STALL) begin
                            pc_out_d    = fetch_pc_q;
                            instr_out_d = bus.IMEM_INSTR;
                            valid_d     = 1'b1;
                            fetch_pc_d  = fetch_pc_q + Step;
                        end else begin
                            skid_pc_d    = fetch_pc_q;
                            skid_instr_d = bus.IMEM_INSTR;
                            state_d      = StHold;
                        end
                    end else if (!bus.STALL) begin
                        valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!bus.STALL) begin
                        pc_out_d    = skid_pc_q;
                        instr_out_d = skid_instr_q;
                        valid_d     = 1'b1;
                        fetch_pc_d  = fetch_pc_q + Step;
                        state_d     = StFetch;
                    end
                end
                StDrain: begin
                    if (done) state_d = StFetch;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_VECTOR;
            drain_addr_q <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            pc_out_q     <= '0;
            instr_out_q  <= Nop;
            valid_q      <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            pc_out_q     <= pc_out_d;
            instr_out_q  <= instr_out_d;
            valid_q      <= valid_d;
            flush_q      <= flush_d;
        end
    end

    assign bus.IMEM_READ   = imem_read;
    assign bus.IMEM_ADDR   = imem_addr;
    assign bus.PC_OUT      = pc_out_q;
    assign bus.INSTR_OUT   = instr_out_q;
    assign bus.INSTR_VALID = valid_q;
    assign bus.FLUSH       = flush_q;
endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Directed bench for if_fetch_sequencer; memory returns instr = addr with scripted busywait.
module tb_if_fetch_sequencer;
    logic CLOCK;
    logic RESET;
    int   checks;
    int   errors;

    if_fetch_sequencer_if bus ();

    if_fetch_sequencer dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    assign bus.IMEM_INSTR = bus.IMEM_ADDR;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks                = 0;
        errors                = 0;
        RESET                 = 1'b1;
        bus.STALL             = 1'b0;
        bus.REDIRECT_EN       = 1'b0;
        bus.REDIRECT_ADDR     = '0;
        bus.IMEM_BUSYWAIT     = 1'b0;

        // 1. Reset, idle cycle, then one instruction per cycle
        tick();
        chk("rst_pc", bus.PC_OUT, 32'h0);
        chk("rst_instr", bus.INSTR_OUT, 32'h13);
        chk("rst_valid", 32'(bus.INSTR_VALID), 0);
        chk("rst_flush", 32'(bus.FLUSH), 0);
        chk("rst_read", 32'(bus.IMEM_READ), 0);
        tick();
        RESET = 1'b0;
        tick();
        chk("idle_read", 32'(bus.IMEM_READ), 1);
        chk("idle_addr", bus.IMEM_ADDR, 32'h0);
        chk("idle_valid", 32'(bus.INSTR_VALID), 0);
        tick();
        chk("seq_pc0", bus.PC_OUT, 32'h0);
        chk("seq_v0", 32'(bus.INSTR_VALID), 1);
        chk("seq_addr4", bus.IMEM_ADDR, 32'h4);
        tick();
        chk("seq_pc4", bus.PC_OUT, 32'h4);
        tick();
        chk("seq_pc8", bus.PC_OUT, 32'h8);
        chk("seq_instr8", bus.INSTR_OUT, 32'h8);
        tick();
        chk("seq_pc12", bus.PC_OUT, 32'hC);
        chk("seq_v12", 32'(bus.INSTR_VALID), 1);

        // 2. Three busy cycles per read
        for (int r = 0; r < 2; r++) begin
            bus.IMEM_BUSYWAIT = 1'b1;
            for (int b = 0; b < 3; b++) begin
                tick();
                chk("busy_valid", 32'(bus.INSTR_VALID), 0);
                chk("busy_addr", bus.IMEM_ADDR, 32'h10 + 32'(4 * r));
            end
            bus.IMEM_BUSYWAIT = 1'b0;
            tick();
            chk("busy_pc", bus.PC_OUT, 32'h10 + 32'(4 * r));
            chk("busy_done_valid", 32'(bus.INSTR_VALID), 1);
        end

        // 3. Stall in a completion cycle for 3 cycles
        bus.STALL = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_pc", bus.PC_OUT, 32'h14);
            chk("stall_valid", 32'(bus.INSTR_VALID), 1);
            chk("hold_read", 32'(bus.IMEM_READ), 0);
        end
        bus.STALL = 1'b0;
        tick();
        chk("skid_pc", bus.PC_OUT, 32'h18);
        chk("skid_instr", bus.INSTR_OUT, 32'h18);
        chk("skid_next_addr", bus.IMEM_ADDR, 32'h1C);
        tick();
        chk("post_skid_pc", bus.PC_OUT, 32'h1C);
        chk("post_skid_valid", 32'(bus.INSTR_VALID), 1);

        // 4. Redirect to 0x100 while read at 0x08 is busy
        bus.REDIRECT_EN   = 1'b1;
        bus.REDIRECT_ADDR = 32'h8;
        tick();
        chk("rd8_flush", 32'(bus.FLUSH), 1);
        chk("rd8_addr", bus.IMEM_ADDR, 32'h8);
        bus.REDIRECT_EN   = 1'b0;
        bus.IMEM_BUSYWAIT = 1'b1;
        tick();
        chk("rd8_flush_off", 32'(bus.FLUSH), 0);
        chk("rd8_busy_valid", 32'(bus.INSTR_VALID), 0);
        bus.REDIRECT_EN   = 1'b1;
        bus.REDIRECT_ADDR = 32'h100;
        tick();
        chk("drain_flush", 32'(bus.FLUSH), 1);
        chk("drain_valid", 32'(bus.INSTR_VALID), 0);
        chk("drain_read", 32'(bus.IMEM_READ), 1);
        chk("drain_addr", bus.IMEM_ADDR, 32'h8);
        bus.REDIRECT_EN = 1'b0;
        tick();
        chk("drain_flush_off", 32'(bus.FLUSH), 0);
        chk("drain_addr_hold", bus.IMEM_ADDR, 32'h8);
        bus.IMEM_BUSYWAIT = 1'b0;
        tick();
        chk("drain_discard", 32'(bus.INSTR_VALID), 0);
        chk("drain_next_addr", bus.IMEM_ADDR, 32'h100);
        tick();
        chk("tgt_pc", bus.PC_OUT, 32'h100);
        chk("tgt_valid", 32'(bus.INSTR_VALID), 1);

        // 5. Redirect together with stall, unaligned target
        bus.REDIRECT_EN   = 1'b1;
        bus.REDIRECT_ADDR = 32'h203;
        bus.STALL         = 1'b1;
        tick();
        chk("rs_flush", 32'(bus.FLUSH), 1);
        chk("rs_valid", 32'(bus.INSTR_VALID), 0);
        chk("rs_addr", bus.IMEM_ADDR, 32'h200);
        bus.REDIRECT_EN = 1'b0;
        bus.STALL       = 1'b0;
        tick();
        chk("rs_pc", bus.PC_OUT, 32'h200);
        chk("rs_flush_off", 32'(bus.FLUSH), 0);

        // 6. Wrap at the top of the address space, then reset mid-drain
        bus.REDIRECT_EN   = 1'b1;
        bus.REDIRECT_ADDR = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr", bus.IMEM_ADDR, 32'hFFFF_FFFC);
        bus.REDIRECT_EN = 1'b0;
        tick();
        chk("wrap_pc_top", bus.PC_OUT, 32'hFFFF_FFFC);
        chk("wrap_addr0", bus.IMEM_ADDR, 32'h0);
        tick();
        chk("wrap_pc0", bus.PC_OUT, 32'h0);
        chk("wrap_valid", 32'(bus.INSTR_VALID), 1);
        bus.IMEM_BUSYWAIT = 1'b1;
        tick();
        bus.REDIRECT_EN   = 1'b1;
        bus.REDIRECT_ADDR = 32'h40;
        tick();
        chk("rd_drain_addr", bus.IMEM_ADDR, 32'h4);
        chk("rd_drain_flush", 32'(bus.FLUSH), 1);
        bus.REDIRECT_EN = 1'b0;
        RESET           = 1'b1;
        tick();
        chk("mid_rst_pc", bus.PC_OUT, 32'h0);
        chk("mid_rst_instr", bus.INSTR_OUT, 32'h13);
        chk("mid_rst_valid", 32'(bus.INSTR_VALID), 0);
        chk("mid_rst_flush", 32'(bus.FLUSH), 0);
        chk("mid_rst_read", 32'(bus.IMEM_READ), 0);
        chk("mid_rst_addr", bus.IMEM_ADDR, 32'h0);
        RESET             = 1'b0;
        bus.IMEM_BUSYWAIT = 1'b0;
        tick();
        chk("restart_read", 32'(bus.IMEM_READ), 1);
        chk("restart_addr", bus.IMEM_ADDR, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
